// File: rtl/serial_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_parity_rx
// Purpose  : Bit-strobed serial receiver for start / DATA_W data (LSB first) /
//            even parity / stop frames. Delivers each word over valid/ready.
//            Optional saturating error counter enabled by `define ERR_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_parity_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              par_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              valid,
    input  logic              ready
`ifdef ERR_COUNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int              CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_par;
    logic               r_drop;

    logic [DATA_W-1:0]  w_shift_next;
    logic               w_par_err;
    logic               w_frame_err;
    logic               w_done;
    logic               w_accept;

    // New bits enter at the MSB so the first data bit lands at bit 0.
    generate
        if (DATA_W == 1) begin : g_shift_single
            assign w_shift_next = rx;
        end else begin : g_shift_multi
            assign w_shift_next = {rx, r_shift[DATA_W-1:1]};
        end
    endgenerate

    assign w_par_err   = ^{r_shift, r_par};
    assign w_frame_err = ~rx;
    assign w_done      = bit_en && (r_state == STOP);
    assign w_accept    = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_drop    <= 1'b0;
            data_out  <= '0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            valid     <= 1'b0;
        end else begin
            if (valid && ready) begin
                valid <= 1'b0;
            end
            if (bit_en) begin
                case (r_state)
                    IDLE: begin
                        if (!rx) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                        end
                    end
                    DATA: begin
                        r_shift <= w_shift_next;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_par   <= rx;
                        r_state <= STOP;
                    end
                    STOP: begin
                        // A stop bit of 0 is reported, never reused as a start bit.
                        r_state <= IDLE;
                        if (w_accept) begin
                            data_out  <= r_shift;
                            par_err   <= w_par_err;
                            frame_err <= w_frame_err;
                            overrun   <= r_drop;
                            valid     <= 1'b1;
                            r_drop    <= 1'b0;
                        end else begin
                            r_drop    <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef ERR_COUNT_EN
    // Counts every completed bad frame, including ones dropped by overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (w_done && (w_par_err || w_frame_err) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_parity_rx
// Purpose  : Scoreboard bench for serial_parity_rx (DATA_W = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_parity_rx;

    localparam int DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              bit_en;
    logic              rx;
    logic [DATA_W-1:0] data_out;
    logic              par_err;
    logic              frame_err;
    logic              overrun;
    logic              valid;
    logic              ready;
`ifdef ERR_COUNT_EN
    logic [7:0]        err_count;
`endif

    serial_parity_rx #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_en    (bit_en),
        .rx        (rx),
        .data_out  (data_out),
        .par_err   (par_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .valid     (valid),
        .ready     (ready)
`ifdef ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_err = 0;

    // Scoreboard: every accepted word is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_extra_word got data=%h pe=%b fe=%b ov=%b, expected none",
                         data_out, par_err, frame_err, overrun);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({data_out, par_err, frame_err, overrun} !== {e.d, e.pe, e.fe, e.ov}) begin
                    n_fail++;
                    $display("FAIL scoreboard_word got data=%h pe=%b fe=%b ov=%b, expected data=%h pe=%b fe=%b ov=%b",
                             data_out, par_err, frame_err, overrun, e.d, e.pe, e.fe, e.ov);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame; returns 1 time unit after the stop-bit sampling edge.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stp,
                              input bit push, input logic ovr, input int gap,
                              input bit rdy_at_stop);
        logic [10:0] fr;
        exp_t        e;
        fr = {stp, p, d, 1'b0};
        if (((^d) ^ p) || !stp) begin
            if (exp_err < 255) exp_err++;
        end
        if (push) begin
            e.d  = d;
            e.pe = (^d) ^ p;
            e.fe = ~stp;
            e.ov = ovr;
            q.push_back(e);
        end
        for (int i = 0; i < 11; i++) begin
            rx     = fr[i];
            bit_en = 1'b1;
            if (i == 10 && rdy_at_stop) ready = 1'b1;
            step();
            bit_en = 1'b0;
            rx     = 1'b1;
            if (i != 10) begin
                repeat (gap) step();
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        n_tests++;
        if ({data_out, par_err, frame_err, overrun, valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got data=%h pe=%b fe=%b ov=%b v=%b, expected all 0",
                     data_out, par_err, frame_err, overrun, valid);
        end
`ifdef ERR_COUNT_EN
        n_tests++;
        if (err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_err_count got %0d expected 0", err_count);
        end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0);
        n_tests++;
        if (valid !== 1'b1 || data_out !== 8'hA5 || par_err !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_word got v=%b data=%h pe=%b fe=%b, expected v=1 data=a5 pe=0 fe=0",
                     valid, data_out, par_err, frame_err);
        end
        step();
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_valid_one_cycle got v=%b expected 0", valid);
        end
    endtask

    task automatic test_parity_err();
        send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0);
        n_tests++;
        if (par_err !== 1'b1 || data_out !== 8'h01) begin
            n_fail++;
            $display("FAIL parity_err got data=%h pe=%b, expected data=01 pe=1", data_out, par_err);
        end
`ifdef ERR_COUNT_EN
        n_tests++;
        if (err_count !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL parity_err_count got %0d expected %0d", err_count, exp_err);
        end
`endif
        step();
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        n_tests++;
        if (frame_err !== 1'b1 || par_err !== 1'b0 || data_out !== 8'h3C) begin
            n_fail++;
            $display("FAIL frame_err got data=%h fe=%b pe=%b, expected data=3c fe=1 pe=0",
                     data_out, frame_err, par_err);
        end
        step();
        send_frame(8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        n_tests++;
        if (frame_err !== 1'b0 || par_err !== 1'b0 || data_out !== 8'h0F) begin
            n_fail++;
            $display("FAIL frame_recover got data=%h fe=%b pe=%b, expected data=0f fe=0 pe=0",
                     data_out, frame_err, par_err);
        end
        step();
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        n_tests++;
        if (valid !== 1'b1 || data_out !== 8'h11 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_hold got v=%b data=%h ov=%b, expected v=1 data=11 ov=0",
                     valid, data_out, overrun);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_release got v=%b expected 0", valid);
        end
        send_frame(8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0);
        n_tests++;
        if (data_out !== 8'h33 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_flag got data=%h ov=%b, expected data=33 ov=1", data_out, overrun);
        end
        ready = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        send_frame(8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        n_tests++;
        if (valid !== 1'b1 || data_out !== 8'h55 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back got v=%b data=%h ov=%b, expected v=1 data=55 ov=0",
                     valid, data_out, overrun);
        end
        step();
    endtask

    task automatic test_mid_frame_reset();
        ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            rx     = (i == 0) ? 1'b0 : 1'(i);
            bit_en = 1'b1;
            step();
        end
        bit_en = 1'b0;
        rx     = 1'b1;
        rst_n  = 1'b0;
        #1;
        q.delete();
        exp_err = 0;
        n_tests++;
        if ({data_out, par_err, frame_err, overrun, valid} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset got data=%h pe=%b fe=%b ov=%b v=%b, expected all 0",
                     data_out, par_err, frame_err, overrun, valid);
        end
        step();
        rst_n = 1'b1;
        ready = 1'b1;
        step();
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0);
        n_tests++;
        if (valid !== 1'b1 || data_out !== 8'h5A || par_err !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset got v=%b data=%h pe=%b ov=%b, expected v=1 data=5a pe=0 ov=0",
                     valid, data_out, par_err, overrun);
        end
        step();
    endtask

    task automatic test_random();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            logic       p;
            logic       s;
            d = 8'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send_frame(d, p, s, 1'b1, 1'b0, int'($urandom_range(0, 2)), 1'b0);
            step();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        bit_en = 1'b0;
        rx     = 1'b1;
        ready  = 1'b0;
        test_reset();
        test_basic();
        test_parity_err();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_mid_frame_reset();
        test_random();
        repeat (2) step();
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d words pending, expected 0", q.size());
        end
`ifdef ERR_COUNT_EN
        n_tests++;
        if (err_count !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL final_err_count got %0d expected %0d", err_count, exp_err);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
